// File: rtl/dac904_clk_monitor.sv
// dac904_clk_monitor: times the divided DAC904 clock in clkDAC_200m cycles.
// Reports lock, mismatched half-periods and a stalled clock against cnt_expected.
module dac904_clk_monitor #(
  parameter int N      = 40,
  parameter int TOL    = 0,
  parameter int LOCK_N = 4
) (
  input  logic         clkDAC_200m,
  input  logic         rst,
  input  logic         clk_mon,
  input  logic [N-1:0] cnt_expected,
  output logic [N+2:0] meas_half,
  output logic         meas_level,
  output logic         meas_valid,
  output logic         locked,
  output logic         stall,
  output logic [15:0]  err_cnt
);

  typedef enum logic [1:0] {ACQ, TRACK, STALL} state_t;

  localparam logic [N+2:0] RUN_ONE = (N+3)'(1);
  localparam logic [N+2:0] RUN_MAX = '1;
  localparam logic [N+2:0] TOL_W   = (N+3)'(TOL);
  localparam logic [3:0]   LOCK_W  = 4'(LOCK_N);

  state_t       r_state;
  logic         r_s1, r_s2, r_s3;
  logic [N-1:0] r_cnt;
  logic [N+2:0] r_runCnt;
  logic [3:0]   r_lockCnt;

  logic         w_edge;
  logic         w_paramChg;
  logic         w_inTol;
  logic [N+2:0] w_exp;
  logic [N+2:0] w_stallThr;
  logic [N+2:0] w_diff;

  assign w_edge     = r_s2 ^ r_s3;
  assign w_paramChg = (cnt_expected != r_cnt);
  assign w_exp      = {3'b000, r_cnt} + RUN_ONE;
  assign w_stallThr = w_exp << 2;
  assign w_diff     = (r_runCnt > w_exp) ? (r_runCnt - w_exp) : (w_exp - r_runCnt);
  assign w_inTol    = (w_diff <= TOL_W);

  always_ff @(posedge clkDAC_200m) begin
    if (!rst) begin
      r_state    <= ACQ;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_cnt      <= cnt_expected;
      r_runCnt   <= '0;
      r_lockCnt  <= '0;
      meas_half  <= '0;
      meas_level <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stall      <= 1'b0;
      err_cnt    <= '0;
    end else begin
      r_s1       <= clk_mon;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_cnt      <= cnt_expected;
      meas_valid <= 1'b0;

      // A new divider value discards any edge in the same cycle and restarts acquisition.
      if (w_paramChg) begin
        r_state   <= ACQ;
        r_runCnt  <= '0;
        r_lockCnt <= '0;
        locked    <= 1'b0;
      end else begin
        if (w_edge)
          r_runCnt <= RUN_ONE;
        else if (r_runCnt != RUN_MAX)
          r_runCnt <= r_runCnt + RUN_ONE;

        case (r_state)
          ACQ: begin
            if (w_edge) begin
              r_state <= TRACK;
              stall   <= 1'b0;
            end
          end
          TRACK: begin
            if (w_edge) begin
              meas_half  <= r_runCnt;
              meas_level <= r_s3;
              meas_valid <= 1'b1;
              if (w_inTol) begin
                if (r_lockCnt < LOCK_W)
                  r_lockCnt <= r_lockCnt + 4'd1;
                if (r_lockCnt >= LOCK_W - 4'd1)
                  locked <= 1'b1;
              end else begin
                if (err_cnt != 16'hFFFF)
                  err_cnt <= err_cnt + 16'd1;
                r_lockCnt <= '0;
                locked    <= 1'b0;
              end
            end else if (r_runCnt == w_stallThr) begin
              r_state   <= STALL;
              stall     <= 1'b1;
              locked    <= 1'b0;
              r_lockCnt <= '0;
              if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            end
          end
          STALL: begin
            // The first edge after a stall only restarts timing.
            if (w_edge) begin
              stall   <= 1'b0;
              r_state <= TRACK;
            end
          end
          default: r_state <= ACQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac904_clk_monitor.sv
// tb_dac904_clk_monitor: directed half-period sequences with a queued scoreboard
// checked against every meas_valid pulse.
module tb_dac904_clk_monitor;
  localparam int N = 40;

  logic         clkDAC_200m = 1'b0;
  logic         rst = 1'b0;
  logic         clk_mon = 1'b0;
  logic [N-1:0] cnt_expected = '0;
  logic [N+2:0] meas_half;
  logic         meas_level;
  logic         meas_valid;
  logic         locked;
  logic         stall;
  logic [15:0]  err_cnt;

  typedef struct {
    logic [N+2:0] half;
    logic         level;
    logic         locked;
    logic [15:0]  err;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   prevLen = 0;

  dac904_clk_monitor #(.N(N), .TOL(0), .LOCK_N(4)) dut (
    .clkDAC_200m (clkDAC_200m),
    .rst         (rst),
    .clk_mon     (clk_mon),
    .cnt_expected(cnt_expected),
    .meas_half   (meas_half),
    .meas_level  (meas_level),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .stall       (stall),
    .err_cnt     (err_cnt)
  );

  always #5 clkDAC_200m = ~clkDAC_200m;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Toggle clk_mon and hold it for len cycles; expPulse means this toggle's edge measures the previous half.
  task automatic applyStimulus(input int len, input bit expPulse, input bit expLocked, input int expErr);
    exp_t e;
    clk_mon = ~clk_mon;
    if (expPulse) begin
      e.half   = (N+3)'(prevLen);
      e.level  = ~clk_mon;
      e.locked = expLocked;
      e.err    = 16'(expErr);
      expQ.push_back(e);
    end
    prevLen = len;
    repeat (len) @(posedge clkDAC_200m);
    #1;
  endtask

  task automatic setParam(input logic [N-1:0] val);
    repeat (3) @(posedge clkDAC_200m);
    #1;
    cnt_expected = val;
    @(posedge clkDAC_200m);
    #1;
    checkOutput("lockedClearOnParam", 64'(locked), 64'd0);
  endtask

  task automatic checkResetValues();
    checkOutput("rstMeasHalf", 64'(meas_half), 64'd0);
    checkOutput("rstMeasLevel", 64'(meas_level), 64'd0);
    checkOutput("rstMeasValid", 64'(meas_valid), 64'd0);
    checkOutput("rstLocked", 64'(locked), 64'd0);
    checkOutput("rstStall", 64'(stall), 64'd0);
    checkOutput("rstErrCnt", 64'(err_cnt), 64'd0);
  endtask

  always @(negedge clkDAC_200m) begin
    exp_t e;
    if (meas_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedPulse: got meas_valid=1 half=%0d, expected no pulse at %0t", meas_half, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("measHalf", 64'(meas_half), 64'(e.half));
        checkOutput("measLevel", 64'(meas_level), 64'(e.level));
        checkOutput("lockedAtPulse", 64'(locked), 64'(e.locked));
        checkOutput("errCntAtPulse", 64'(err_cnt), 64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cnt_expected = 40'd4;
    repeat (3) @(posedge clkDAC_200m);
    #1;
    checkResetValues();
    rst = 1'b1;
    @(posedge clkDAC_200m);
    #1;

    // Nominal divider 4: half-period 5, lock on the 4th pulse.
    applyStimulus(5, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(5, 1'b1, (i >= 4), 0);

    // Minimum divider: toggle every cycle.
    setParam(40'd0);
    applyStimulus(1, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(1, 1'b1, (i >= 4), 0);

    // Mismatch: one 7-cycle half while locked at divider 9.
    setParam(40'd9);
    applyStimulus(10, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(10, 1'b1, (i >= 4), 0);
    applyStimulus(7, 1'b1, 1'b1, 0);
    applyStimulus(10, 1'b1, 1'b0, 1);
    for (int i = 1; i <= 4; i++) applyStimulus(10, 1'b1, (i >= 4), 1);

    // Stall: divider 3, threshold 16.
    setParam(40'd3);
    applyStimulus(4, 1'b0, 1'b0, 1);
    for (int i = 1; i <= 4; i++) applyStimulus(4, 1'b1, (i >= 4), 1);
    applyStimulus(18, 1'b1, 1'b1, 1);
    checkOutput("stallBeforeThreshold", 64'(stall), 64'd0);
    @(posedge clkDAC_200m);
    #1;
    checkOutput("stallRise", 64'(stall), 64'd1);
    checkOutput("stallLocked", 64'(locked), 64'd0);
    checkOutput("stallErrCnt", 64'(err_cnt), 64'd2);
    repeat (10) @(posedge clkDAC_200m);
    #1;
    checkOutput("stallHeld", 64'(stall), 64'd1);
    checkOutput("stallErrOnce", 64'(err_cnt), 64'd2);
    applyStimulus(4, 1'b0, 1'b0, 2);
    checkOutput("stallClear", 64'(stall), 64'd0);
    for (int i = 1; i <= 4; i++) applyStimulus(4, 1'b1, (i >= 4), 2);

    // Parameter change 4 -> 6 while locked.
    setParam(40'd4);
    applyStimulus(5, 1'b0, 1'b0, 2);
    for (int i = 1; i <= 5; i++) applyStimulus(5, 1'b1, (i >= 4), 2);
    setParam(40'd6);
    applyStimulus(7, 1'b0, 1'b0, 2);
    for (int i = 1; i <= 4; i++) applyStimulus(7, 1'b1, (i >= 4), 2);

    // Build err_cnt=3 and relock, then reset mid-run.
    applyStimulus(5, 1'b1, 1'b1, 2);
    applyStimulus(7, 1'b1, 1'b0, 3);
    for (int i = 1; i <= 4; i++) applyStimulus(7, 1'b1, (i >= 4), 3);
    applyStimulus(3, 1'b1, 1'b1, 3);
    rst = 1'b0;
    clk_mon = 1'b0;
    @(posedge clkDAC_200m);
    #1;
    checkResetValues();
    repeat (2) @(posedge clkDAC_200m);
    #1;
    rst = 1'b1;
    @(posedge clkDAC_200m);
    #1;
    applyStimulus(7, 1'b0, 1'b0, 0);
    applyStimulus(7, 1'b1, 1'b0, 0);
    repeat (6) @(posedge clkDAC_200m);
    #1;
    checkOutput("pendingPulses", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
